// File: rtl/mem_access_ctrl.sv
// LC-3b memory-stage controller: data-memory handshake, LDI/STI
// indirection, byte lanes, pipeline stall and write-back register.
module mem_access_ctrl #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic [3:0]        mem_opcode,
  input  logic [WORD_W-1:0] mem_address,
  input  logic [WORD_W-1:0] mem_alu_out,
  input  logic [WORD_W-1:0] mem_store_data,
  input  logic              dmem_resp,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [WORD_W-1:0] dmem_address,
  output logic [WORD_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_enable,
  output logic              stall_out,
  output logic              wb_valid,
  output logic [WORD_W-1:0] wb_data
);

  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    INDIRECT,
    DONE
  } state_t;

  state_t state;

  logic              is_ldb, is_stb, is_ldr, is_str;
  logic              is_ldi, is_sti, is_trap;
  logic              is_load, is_mem;
  logic [WORD_W-1:0] ind_ptr;
  logic [WORD_W-1:0] ld_data;
  logic [WORD_W-1:0] ld_fmt;
  logic [7:0]        ld_byte;

  assign is_ldb  = mem_opcode == OP_LDB;
  assign is_stb  = mem_opcode == OP_STB;
  assign is_ldr  = mem_opcode == OP_LDR;
  assign is_str  = mem_opcode == OP_STR;
  assign is_ldi  = mem_opcode == OP_LDI;
  assign is_sti  = mem_opcode == OP_STI;
  assign is_trap = mem_opcode == OP_TRAP;

  assign is_load = is_ldr | is_ldb | is_ldi | is_trap;
  assign is_mem  = mem_valid &
                   (is_load | is_str | is_stb | is_sti);

  // LDB picks the lane named by the effective address, not the pointer
  assign ld_byte = mem_address[0] ? dmem_rdata[15:8]
                                  : dmem_rdata[7:0];
  assign ld_fmt  = is_ldb ? {{8{ld_byte[7]}}, ld_byte}
                          : dmem_rdata;

  assign stall_out = (state == IDLE && is_mem) ||
                     state == ACCESS ||
                     state == INDIRECT;

  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b00;
    unique case (1'b1)
      (state == ACCESS): begin
        dmem_address = {mem_address[WORD_W-1:1], 1'b0};
        if (is_str) begin
          dmem_write       = 1'b1;
          dmem_wdata       = mem_store_data;
          dmem_byte_enable = 2'b11;
        end else if (is_stb) begin
          dmem_write       = 1'b1;
          dmem_wdata       = {mem_store_data[7:0],
                              mem_store_data[7:0]};
          dmem_byte_enable = mem_address[0] ? 2'b10
                                            : 2'b01;
        end else begin
          dmem_read = 1'b1;
        end
      end
      (state == INDIRECT): begin
        dmem_address = {ind_ptr[WORD_W-1:1], 1'b0};
        if (is_sti) begin
          dmem_write       = 1'b1;
          dmem_wdata       = mem_store_data;
          dmem_byte_enable = 2'b11;
        end else begin
          dmem_read = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ind_ptr  <= '0;
      ld_data  <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) state <= ACCESS;
        end
        ACCESS: begin
          if (dmem_resp) begin
            if (is_ldi || is_sti) begin
              ind_ptr <= dmem_rdata;
              state   <= INDIRECT;
            end else begin
              if (is_load) ld_data <= ld_fmt;
              state <= DONE;
            end
          end
        end
        INDIRECT: begin
          if (dmem_resp) begin
            if (is_ldi) ld_data <= ld_fmt;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      // stalled cycles retire a bubble and keep the last result
      if (stall_out) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid <= mem_valid;
        wb_data  <= (state == DONE && is_load) ? ld_data
                                               : mem_alu_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: queued write-back and memory
// request expectations, checked by independent monitor processes.
module tb_mem_access_ctrl;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } req_t;

  logic        clk;
  logic        reset_n;
  logic        mem_valid;
  logic [3:0]  mem_opcode;
  logic [15:0] mem_address;
  logic [15:0] mem_alu_out;
  logic [15:0] mem_store_data;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        stall_out;
  logic        wb_valid;
  logic [15:0] wb_data;

  int tests = 0;
  int fails = 0;
  int rw_both = 0;
  int lats [2];
  bit mem_en;

  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_wb [$];
  req_t        exp_req [$];

  mem_access_ctrl #(.WORD_W(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_valid        (mem_valid),
    .mem_opcode       (mem_opcode),
    .mem_address      (mem_address),
    .mem_alu_out      (mem_alu_out),
    .mem_store_data   (mem_store_data),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .stall_out        (stall_out),
    .wb_valid         (wb_valid),
    .wb_data          (wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  task automatic push_req(input logic wr, input logic [15:0] a,
                          input logic [15:0] wd,
                          input logic [1:0] be);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = wd; r.be = be;
    exp_req.push_back(r);
  endtask

  // write-back monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (exp_wb.size() == 0) begin
          tests++; fails++;
          $display("FAIL wb_unexpected: got %h expected none",
                   wb_data);
        end else begin
          check("wb_data", wb_data, exp_wb.pop_front());
        end
      end
    end
  end

  // memory responder and request monitor
  initial begin
    int cnt = 0;
    int k = 0;
    logic [15:0] tmp;
    req_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!mem_en || !(dmem_read || dmem_write)) begin
        if (mem_en) dmem_resp = 1'b0;
        cnt = 0;
        k = 0;
      end else begin
        if (dmem_read && dmem_write) rw_both++;
        cnt++;
        if (cnt == lats[k]) begin
          dmem_resp = 1'b1;
          dmem_rdata = dmem_write ? 16'h0000 : rd(dmem_address);
          if (exp_req.size() == 0) begin
            tests++; fails++;
            $display("FAIL req_unexpected: got addr %h expected none",
                     dmem_address);
          end else begin
            e = exp_req.pop_front();
            check("req_write", {15'd0, dmem_write}, {15'd0, e.wr});
            check("req_addr", dmem_address, e.addr);
            if (e.wr) begin
              check("req_wdata", dmem_wdata, e.wdata);
              check("req_be", {14'd0, dmem_byte_enable},
                    {14'd0, e.be});
            end
          end
          if (dmem_write) begin
            tmp = rd(dmem_address);
            if (dmem_byte_enable[1]) tmp[15:8] = dmem_wdata[15:8];
            if (dmem_byte_enable[0]) tmp[7:0] = dmem_wdata[7:0];
            mem[dmem_address] = tmp;
          end
          cnt = 0;
          k = (k == 0) ? 1 : 0;
        end else begin
          dmem_resp = 1'b0;
        end
      end
    end
  end

  // issue one instruction at a negedge and count its stall cycles
  task automatic run_op(input string nm, input logic v,
                        input logic [3:0] op,
                        input logic [15:0] a, alu, sd,
                        input int l0, l1, exp_stall);
    int n;
    lats[0] = l0;
    lats[1] = l1;
    mem_valid = v;
    mem_opcode = op;
    mem_address = a;
    mem_alu_out = alu;
    mem_store_data = sd;
    #1;
    n = 0;
    while (stall_out && n < 60) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (n >= 60) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got %0d stall cycles expected %0d",
               nm, n, exp_stall);
    end else begin
      check({nm, "_stall"}, n[15:0], exp_stall[15:0]);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    mem_opcode = 4'b0000;
  endtask

  initial begin
    reset_n = 1'b0;
    mem_en = 1'b1;
    lats[0] = 1;
    lats[1] = 1;
    mem_valid = 1'b0;
    mem_opcode = 4'b0000;
    mem_address = 16'h0000;
    mem_alu_out = 16'h0000;
    mem_store_data = 16'h0000;
    dmem_resp = 1'b0;
    dmem_rdata = 16'h0000;
    mem[16'h3000] = 16'hBEEF;
    mem[16'h4000] = 16'h80FF;
    mem[16'h6000] = 16'h7002;
    mem[16'h7002] = 16'h0042;
    mem[16'h0020] = 16'h2468;

    repeat (2) @(negedge clk);
    #1;
    check("rst_wb_valid", {15'd0, wb_valid}, 16'h0000);
    check("rst_wb_data", wb_data, 16'h0000);
    check("rst_read", {15'd0, dmem_read}, 16'h0000);
    check("rst_write", {15'd0, dmem_write}, 16'h0000);
    check("rst_stall", {15'd0, stall_out}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    exp_wb.push_back(16'h1234);
    run_op("add", 1, 4'b0001, 16'h0000, 16'h1234, 16'h0, 1, 1, 0);

    run_op("ldr_nv", 0, 4'b0110, 16'h3001, 16'h0, 16'h0, 1, 1, 0);

    push_req(0, 16'h3000, 16'h0, 2'b00);
    exp_wb.push_back(16'hBEEF);
    run_op("ldr", 1, 4'b0110, 16'h3001, 16'h0, 16'h0, 2, 1, 3);

    push_req(0, 16'h4000, 16'h0, 2'b00);
    exp_wb.push_back(16'hFF80);
    run_op("ldb_hi", 1, 4'b0010, 16'h4001, 16'h0, 16'h0, 1, 1, 2);

    push_req(0, 16'h4000, 16'h0, 2'b00);
    exp_wb.push_back(16'hFFFF);
    run_op("ldb_lo", 1, 4'b0010, 16'h4000, 16'h0, 16'h0, 1, 1, 2);

    push_req(1, 16'h5000, 16'hA5A5, 2'b10);
    exp_wb.push_back(16'h5001);
    run_op("stb_hi", 1, 4'b0011, 16'h5001, 16'h5001, 16'h00A5,
           1, 1, 2);

    push_req(1, 16'h5000, 16'h3434, 2'b01);
    exp_wb.push_back(16'h0777);
    run_op("stb_lo", 1, 4'b0011, 16'h5000, 16'h0777, 16'h1234,
           1, 1, 2);

    push_req(1, 16'h5002, 16'hBEAD, 2'b11);
    exp_wb.push_back(16'h0ABC);
    run_op("str", 1, 4'b0111, 16'h5003, 16'h0ABC, 16'hBEAD, 3, 1, 4);

    push_req(0, 16'h6000, 16'h0, 2'b00);
    push_req(0, 16'h7002, 16'h0, 2'b00);
    exp_wb.push_back(16'h0042);
    run_op("ldi", 1, 4'b1010, 16'h6000, 16'h0, 16'h0, 1, 3, 5);

    push_req(0, 16'h6000, 16'h0, 2'b00);
    push_req(1, 16'h7002, 16'hCAFE, 2'b11);
    exp_wb.push_back(16'h0100);
    run_op("sti", 1, 4'b1011, 16'h6001, 16'h0100, 16'hCAFE, 1, 1, 3);

    push_req(0, 16'h6000, 16'h0, 2'b00);
    push_req(0, 16'h7002, 16'h0, 2'b00);
    exp_wb.push_back(16'hCAFE);
    run_op("ldi2", 1, 4'b1010, 16'h6000, 16'h0, 16'h0, 2, 2, 5);

    push_req(0, 16'h0020, 16'h0, 2'b00);
    exp_wb.push_back(16'h2468);
    run_op("trap", 1, 4'b1111, 16'h0021, 16'h0, 16'h0, 1, 1, 2);

    // reset while the indirect read is outstanding
    lats[0] = 1;
    lats[1] = 0;
    push_req(0, 16'h6000, 16'h0, 2'b00);
    mem_valid = 1'b1;
    mem_opcode = 4'b1010;
    mem_address = 16'h6000;
    mem_alu_out = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("ind_read", {15'd0, dmem_read}, 16'h0001);
    check("ind_addr", dmem_address, 16'h7002);
    reset_n = 1'b0;
    #1;
    check("arst_read", {15'd0, dmem_read}, 16'h0000);
    check("arst_write", {15'd0, dmem_write}, 16'h0000);
    check("arst_wb_valid", {15'd0, wb_valid}, 16'h0000);
    check("arst_stall", {15'd0, stall_out}, 16'h0001);
    mem_en = 1'b0;
    mem_valid = 1'b0;
    mem_opcode = 4'b0000;
    dmem_resp = 1'b0;
    #1;
    check("arst_stall_nv", {15'd0, stall_out}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b1;
    dmem_rdata = 16'hFFFF;
    @(negedge clk);
    dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_req", {14'd0, dmem_read, dmem_write}, 16'h0000);
      check("post_rst_stall", {15'd0, stall_out}, 16'h0000);
      check("post_rst_wb", {15'd0, wb_valid}, 16'h0000);
      @(negedge clk);
    end
    mem_en = 1'b1;

    exp_wb.push_back(16'h5A5A);
    run_op("add2", 1, 4'b0001, 16'h0000, 16'h5A5A, 16'h0, 1, 1, 0);

    repeat (3) @(negedge clk);
    check("wb_queue_empty", exp_wb.size(), 16'd0);
    check("req_queue_empty", exp_req.size(), 16'd0);
    check("rw_exclusive", rw_both[15:0], 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage controller for the pipelined LC-3b datapath. It sits directly downstream of the execute stage and consumes its effective address and ALU result, together with the decoded opcode and store data. For load, store, indirect and trap operations it runs the data-memory handshake, including the two-access LDI/STI sequence and LDB/STB byte lane handling. While an access is outstanding it stalls the pipeline, then delivers a registered result and valid flag to the write-back latch.

## Interface
Parameters:
- WORD_W, 16, data/address width; only 16 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  EX/MEM latch holds a valid instruction.
- mem_opcode  in  4  LC-3b opcode: LDR 0110, STR 0111, LDB 0010, STB 0011, LDI 1010, STI 1011, TRAP 1111. All others are non-memory.
- mem_address  in  16  effective address from execute.
- mem_alu_out  in  16  ALU result from execute.
- mem_store_data  in  16  SR value for stores.
- dmem_resp  in  1  memory has completed the current request.
- dmem_rdata  in  16  read data; valid when dmem_resp=1.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_address  out  16  word-aligned request address; bit 0 is always 0.
- dmem_wdata  out  16  write data.
- dmem_byte_enable  out  2  write lane enables: [1] high byte, [0] low byte.
- stall_out  out  1  freezes IF/ID/EX and the EX/MEM latch.
- wb_valid  out  1  registered: wb_data holds a retired result.
- wb_data  out  16  registered result to the write-back latch.

## Operation
- Memory op = mem_valid=1 and mem_opcode is one of the seven memory opcodes.
- FSM states: IDLE, ACCESS, INDIRECT, DONE.
- IDLE
  - Memory op: stall_out=1 combinationally, no request; next state ACCESS.
  - Otherwise: stall_out=0, pass-through.
- ACCESS: stall_out=1. Drives the first access:
  - LDR/LDI/STI/TRAP/LDB: read at {mem_address[15:1],0}.
  - STR: write mem_store_data, byte_enable 11.
  - STB: write {mem_store_data[7:0], mem_store_data[7:0]}; byte_enable 10 if mem_address[0]=1, else 01.
  - On dmem_resp:
    - LDI/STI: capture dmem_rdata into ind_ptr; next state INDIRECT.
    - Loads and TRAP: capture the result into ld_data; next state DONE.
    - Stores: next state DONE.
- INDIRECT: stall_out=1.
  - LDI: read at {ind_ptr[15:1],0}.
  - STI: write mem_store_data, byte_enable 11, at {ind_ptr[15:1],0}.
  - On dmem_resp: LDI captures ld_data. Next state DONE.
- DONE: stall_out=0, no request; next state IDLE. The upstream latch advances on this edge, so the instruction is not retriggered.
- Load result formation:
  - LDR/LDI/TRAP: dmem_rdata unchanged.
  - LDB: selected byte (addr[0]=1 → high byte) sign-extended to 16 bits.
- Write-back register:
  - Every edge with stall_out=0: wb_valid<=mem_valid.
    - wb_data<=ld_data in DONE for loads/TRAP.
    - Otherwise wb_data<=mem_alu_out.
  - Every edge with stall_out=1: wb_valid<=0 (bubble); wb_data holds.
- Requests are Moore outputs decoded from the state only. dmem_read and dmem_write are never both 1.
- When idle, dmem_wdata=0 and byte_enable=00.
- dmem_resp is ignored in IDLE and DONE.
- Upstream holds all mem_* inputs stable while stall_out=1.

## Timing
- Reset (async assert): state IDLE; wb_valid=0, wb_data=0x0000, ind_ptr=0, ld_data=0.
  - dmem_read=dmem_write=0 immediately.
  - stall_out follows the IDLE rule.
- Reset mid-access: the request is dropped in the same cycle. A late dmem_resp after release is ignored.
- Non-memory op: 0 stall cycles; wb_valid/wb_data update on the next edge.
- Single access with memory latency L cycles (dmem_resp in the L-th ACCESS cycle, L≥1): stall_out high for 1+L cycles, DONE on the next cycle, then the result appears at wb_data one edge after DONE.
- LDI/STI: stall for 1+L1+L2 cycles, then DONE.
- dmem_resp held high across cycles is consumed once per state transition.

## Test plan
- ADD, mem_alu_out=0x1234, mem_valid=1 → no stall; next edge wb_valid=1, wb_data=0x1234.
- LDR at 0x3001, memory L=2, rdata 0xBEEF → dmem_address=0x3000, read high 2 cycles, stall 3 cycles; after DONE, wb_data=0xBEEF, wb_valid=1 exactly once.
- LDB at 0x4001, rdata 0x80FF → wb_data=0xFF80. Same access at 0x4000 → wb_data=0xFFFF.
- STB at 0x5001, store_data=0x00A5 → dmem_write=1, wdata=0xA5A5, byte_enable=10, dmem_address=0x5000, wb_valid=1 after DONE.
- LDI at 0x6000, pointer 0x7002, final rdata 0x0042 → two reads (0x6000 then 0x7002), wb_data=0x0042. STI to the same addresses → read 0x6000, then write at 0x7002 with byte_enable 11.
- Assert reset_n=0 during INDIRECT, then release and pulse dmem_resp → requests low immediately, wb_valid=0, FSM stays IDLE, no write-back.
